crc8_ser: RTL and testbench

CRC8_SER -- requirements
Module: crc8_ser

---
 rtl/crc8_ser.sv | 98 +++++++++
 tb/tb_crc8_ser.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/crc8_ser.sv
// Bit-serial CRC-8 engine (MSB-first) with a start/last framed protocol.
// Optional receive-side residue check on crc_ok when CRC8_SER_CHECK_EN is defined.
module crc8_ser #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       last,
  output logic       busy,
  output logic [7:0] crc_out,
  output logic       crc_valid
`ifdef CRC8_SER_CHECK_EN
  ,
  output logic       crc_ok
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] crc, crc_next;

  function automatic logic [7:0] crc_step(input logic [7:0] cur, input logic b);
    logic fb;
    fb = cur[7] ^ b;
    return {cur[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latches.
    state_next = state;
    crc_next   = crc;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          crc_next   = INIT;
        end
      end
      RUN: begin
        // start wins over a coincident bit, which is dropped
        if (start) begin
          crc_next = INIT;
        end else if (bit_valid) begin
          crc_next = crc_step(crc, bit_in);
          if (last) state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          crc_next   = INIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        crc_next   = INIT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      crc   <= INIT;
    end else begin
      state <= state_next;
      crc   <= crc_next;
    end
  end

  assign busy      = (state != IDLE);
  assign crc_valid = (state == DONE);
  assign crc_out   = crc;

`ifdef CRC8_SER_CHECK_EN
  // Registered alongside the DONE transition so it lines up with crc_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_ok <= 1'b0;
    end else begin
      crc_ok <= (state_next == DONE) && (crc_next == 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_crc8_ser.sv
// Directed self-checking bench for crc8_ser (POLY=8'h07, INIT=8'h00).
// Residue-check scenario is compiled in only when CRC8_SER_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_crc8_ser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, bit_in, bit_valid, last;
  logic       busy, crc_valid;
  logic [7:0] crc_out;
`ifdef CRC8_SER_CHECK_EN
  logic       crc_ok;
`endif

  int passed = 0;
  int total  = 0;
  int valid_pulses = 0;
  int busy_low = 0;
  bit track_busy = 1'b0;

  crc8_ser #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .last      (last),
    .busy      (busy),
    .crc_out   (crc_out),
    .crc_valid (crc_valid)
`ifdef CRC8_SER_CHECK_EN
    ,
    .crc_ok    (crc_ok)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (crc_valid) valid_pulses++;

  // Drive one cycle of inputs at the falling edge; optionally note busy drops.
  task automatic drive(input logic s, input logic bv, input logic bi, input logic l);
    @(negedge clk);
    if (track_busy && !busy) busy_low++;
    start = s; bit_valid = bv; bit_in = bi; last = l;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_last, input int gap);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b0, 1'b1, b[i], is_last && (i == 0));
      if (i != 0)
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; bit_in = 0; bit_valid = 0; last = 0;
    #3;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (crc_out !== 8'h00) $display("FAIL reset_crc got=%h exp=00", crc_out); else passed++;
    total++; if (crc_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", crc_valid); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
  endtask

  task automatic test_check_string;
    logic [7:0] msg [9];
    int v0;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    v0 = valid_pulses;
    drive(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) send_byte(msg[k], k == 8, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_valid !== 1'b1) $display("FAIL str_valid got=%b exp=1", crc_valid); else passed++;
    total++; if (crc_out !== 8'hF4) $display("FAIL str_crc got=%h exp=f4", crc_out); else passed++;
    drive(0, 0, 0, 0);
    total++; if (busy !== 1'b0 || crc_out !== 8'hF4)
      $display("FAIL str_hold busy=%b crc=%h exp busy=0 crc=f4", busy, crc_out); else passed++;
    total++; if (valid_pulses - v0 !== 1) $display("FAIL str_pulses got=%0d exp=1", valid_pulses - v0); else passed++;
  endtask

  task automatic test_gaps;
    int v0;
    v0 = valid_pulses;
    drive(1, 0, 0, 0);
    send_byte(8'h80, 1'b1, 3);
    drive(0, 0, 0, 0);
    total++; if (crc_valid !== 1'b1 || crc_out !== 8'h89)
      $display("FAIL gap_done valid=%b crc=%h exp valid=1 crc=89", crc_valid, crc_out); else passed++;
    repeat (3) drive(0, 0, 0, 0);
    total++; if (valid_pulses - v0 !== 1) $display("FAIL gap_pulses got=%0d exp=1", valid_pulses - v0); else passed++;
  endtask

  task automatic test_abort_restart;
    int v0;
    v0 = valid_pulses;
    drive(1, 0, 0, 0);
    track_busy = 1'b0;
    drive(0, 1, 1, 0);
    track_busy = 1'b1; busy_low = 0;
    drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_out !== 8'h38) $display("FAIL abort_mid got=%h exp=38", crc_out); else passed++;
    drive(1, 0, 0, 0);
    send_byte(8'h01, 1'b1, 0);
    drive(0, 0, 0, 0);
    track_busy = 1'b0;
    total++; if (crc_valid !== 1'b1 || crc_out !== 8'h07)
      $display("FAIL abort_crc valid=%b crc=%h exp valid=1 crc=07", crc_valid, crc_out); else passed++;
    total++; if (busy_low !== 0) $display("FAIL abort_busy low_cycles=%0d exp=0", busy_low); else passed++;
    drive(0, 0, 0, 0);
    total++; if (valid_pulses - v0 !== 1) $display("FAIL abort_pulses got=%0d exp=1", valid_pulses - v0); else passed++;
  endtask

  task automatic test_async_reset;
    int v0;
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_out !== 8'h2D) $display("FAIL areset_pre got=%h exp=2d", crc_out); else passed++;
    v0 = valid_pulses;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || crc_out !== 8'h00)
      $display("FAIL areset_now busy=%b crc=%h exp busy=0 crc=00", busy, crc_out); else passed++;
    drive(0, 1, 1, 1);
    rst_n = 1'b1;
    repeat (4) drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
    total++; if (valid_pulses - v0 !== 0 || busy !== 1'b0)
      $display("FAIL areset_after pulses=%0d busy=%b exp pulses=0 busy=0", valid_pulses - v0, busy); else passed++;
  endtask

  task automatic test_idle_ignore;
    drive(1, 0, 0, 0);
    send_byte(8'h80, 1'b1, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 1, 1); drive(0, 1, 1, 0); drive(0, 1, 0, 1);
    drive(0, 0, 0, 0);
    total++; if (crc_out !== 8'h89 || busy !== 1'b0)
      $display("FAIL idle_ignore crc=%h busy=%b exp crc=89 busy=0", crc_out, busy); else passed++;
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_out !== 8'h00 || busy !== 1'b1)
      $display("FAIL start_discard crc=%h busy=%b exp crc=00 busy=1", crc_out, busy); else passed++;
    send_byte(8'h01, 1'b1, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_valid !== 1'b1 || crc_out !== 8'h07)
      $display("FAIL idle_byte valid=%b crc=%h exp valid=1 crc=07", crc_valid, crc_out); else passed++;
  endtask

`ifdef CRC8_SER_CHECK_EN
  task automatic test_residue;
    logic [7:0] msg [10];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    drive(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) send_byte(msg[k], k == 9, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_valid !== 1'b1 || crc_out !== 8'h00 || crc_ok !== 1'b1)
      $display("FAIL residue_ok valid=%b crc=%h ok=%b exp 1/00/1", crc_valid, crc_out, crc_ok); else passed++;
    drive(0, 0, 0, 0);
    total++; if (crc_ok !== 1'b0) $display("FAIL residue_clear got=%b exp=0", crc_ok); else passed++;
    drive(1, 0, 0, 0);
    send_byte(8'h31, 1'b1, 0);
    drive(0, 0, 0, 0);
    total++; if (crc_valid !== 1'b1 || crc_ok !== 1'b0)
      $display("FAIL residue_bad valid=%b ok=%b exp valid=1 ok=0", crc_valid, crc_ok); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_check_string();
    test_gaps();
    test_abort_restart();
    test_async_reset();
    test_idle_ignore();
`ifdef CRC8_SER_CHECK_EN
    test_residue();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
